// File: rtl/decode_scoreboard.sv
// Register scoreboard and issue controller for the decode stage.
// Tracks in-flight destination registers (timed ALU writes and
// writeback-retired loads) and raises stall_d on RAW/WAW hazards or
// when execute cannot accept an instruction.
module decode_scoreboard #(
  parameter int FIX_LAT = 3,
  parameter int LAT_W   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic        dec_use_rs1,
  input  logic        dec_use_rs2,
  input  logic        dec_we,
  input  logic        dec_is_load,
  input  logic        issue_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        stall_d,
  output logic        issue,
  output logic [31:0] pending,
  output logic [5:0]  busy_cnt,
  output logic        wb_err
);

  localparam logic [LAT_W-1:0] FIX_LAT_T = LAT_W'(FIX_LAT);
  localparam logic [LAT_W-1:0] ONE_T     = LAT_W'(1);

  logic [31:0]      pending_q, pending_d;
  logic [LAT_W-1:0] timer_q [32];
  logic [LAT_W-1:0] timer_d [32];
  logic             wb_err_q, wb_err_d;

  logic [31:0] clear_now;
  logic [31:0] pend_eff;
  logic [31:0] set_now;
  logic        raw1, raw2, waw, hazard;

  // Per-register retire detection and next-state; x0 is hardwired empty.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0) begin : g_x0
        assign clear_now[gi] = 1'b0;
        assign set_now[gi]   = 1'b0;
        assign pending_d[gi] = 1'b0;
        assign timer_d[gi]   = '0;
      end else begin : g_xn
        // Timed entries retire when the countdown reaches 1; load entries
        // (timer parked at 0) retire on a matching writeback.
        assign clear_now[gi] = pending_q[gi] &
                               ((timer_q[gi] == ONE_T) |
                                ((timer_q[gi] == '0) & wb_valid & (wb_rd == 5'(gi))));
        assign set_now[gi]   = issue & dec_we & (dec_rd == 5'(gi));
        // A new issue to this register wins over a same-cycle retire.
        assign pending_d[gi] = set_now[gi] | (pending_q[gi] & ~clear_now[gi]);
        assign timer_d[gi]   = set_now[gi]   ? (dec_is_load ? '0 : FIX_LAT_T) :
                               clear_now[gi] ? '0 :
                               (pending_q[gi] && (timer_q[gi] > ONE_T)) ? (timer_q[gi] - ONE_T) :
                               timer_q[gi];
      end
      // Register file writes before it reads, so a retiring entry is not a hazard.
      assign pend_eff[gi] = pending_q[gi] & ~clear_now[gi];
    end
  endgenerate

  // Hazard detection and issue handshake, purely combinational on registered state.
  always_comb begin
    raw1    = dec_use_rs1 & (dec_rs1 != 5'd0) & pend_eff[dec_rs1];
    raw2    = dec_use_rs2 & (dec_rs2 != 5'd0) & pend_eff[dec_rs2];
    waw     = dec_we & (dec_rd != 5'd0) & pend_eff[dec_rd];
    hazard  = dec_valid & (raw1 | raw2 | waw);
    stall_d = hazard | (dec_valid & ~issue_ready);
    issue   = dec_valid & ~hazard & issue_ready;
  end

  // Sticky error for a writeback that does not match an outstanding load.
  always_comb begin
    wb_err_d = wb_err_q;
    if (wb_valid &&
        ((wb_rd == 5'd0) || !pending_q[wb_rd] || (timer_q[wb_rd] != '0))) begin
      wb_err_d = 1'b1;
    end
  end

  // State registers; reset discards all in-flight entries and the error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      for (int r = 0; r < 32; r++) begin
        timer_q[r] <= '0;
      end
      wb_err_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      for (int r = 0; r < 32; r++) begin
        timer_q[r] <= timer_d[r];
      end
      wb_err_q <= wb_err_d;
    end
  end

  assign pending  = pending_q;
  assign busy_cnt = 6'($countones(pending_q));
  assign wb_err   = wb_err_q;

endmodule
